sha256_block_scheduler: RTL and testbench

SHA256_BLOCK_SCHEDULER -- requirements
Module: sha256_block_scheduler

---
 rtl/sha256_sched_pkg.sv | 17 +
 rtl/sha256_rr_arbiter.sv | 27 ++
 rtl/sha256_block_scheduler.sv | 133 +++++++++++++
 tb/tb_sha256_block_scheduler.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_sched_pkg.sv
// Shared constants and FSM state type for the SHA-256 block scheduler.
package sha256_sched_pkg;

    localparam int unsigned BLOCK_W = 512;
    localparam int unsigned HASH_W  = 256;

    localparam logic [HASH_W-1:0] SHA256_IV =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StWriteback
    } sched_state_e;

endpackage

// File: rtl/sha256_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr, wrapping.
module sha256_rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = PTR_W'((ptr + i) % NUM_REQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sha256_block_scheduler.sv
// Shares one SHA-256 compression core between NUM_REQ requesters, keeping a chaining
// context per requester. Optional WAIT timeout enabled by defining SHA256_SCHED_TIMEOUT_EN.
module sha256_block_scheduler
    import sha256_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned TIMEOUT_CYCLES = 128
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*BLOCK_W-1:0] req_block,
    input  logic [NUM_REQ-1:0]         req_first,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       core_start,
    output logic [BLOCK_W-1:0]         core_block,
    output logic [HASH_W-1:0]          core_hash_in,
    input  logic                       core_done,
    input  logic [HASH_W-1:0]          core_hash_out,
    output logic [NUM_REQ-1:0]         digest_valid,
    output logic [HASH_W-1:0]          digest_out,
    output logic                       busy,
    output logic                       timeout_err
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    sched_state_e        state_q;
    logic [PTR_W-1:0]    rr_ptr_q;
    logic [PTR_W-1:0]    lat_g_q;
    logic                lat_last_q;
    logic [HASH_W-1:0]   ctx_q [NUM_REQ];
    logic [NUM_REQ-1:0]  grant;
    logic [PTR_W-1:0]    grant_idx;

`ifdef SHA256_SCHED_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] wait_cnt_q;
    logic             timeout_q;
    assign timeout_err = timeout_q;
`else
    assign timeout_err = 1'b0;
`endif

    sha256_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .grant (grant)
    );

    always_comb begin
        grant_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) grant_idx = PTR_W'(i);
        end
    end

    // Accept is combinational so the requester sees its handshake in the grant cycle.
    assign req_ready = (state_q == StIdle) ? grant : '0;
    assign busy      = (state_q != StIdle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            rr_ptr_q     <= '0;
            lat_g_q      <= '0;
            lat_last_q   <= 1'b0;
            for (int unsigned i = 0; i < NUM_REQ; i++) ctx_q[i] <= SHA256_IV;
            core_start   <= 1'b0;
            core_block   <= '0;
            core_hash_in <= '0;
            digest_valid <= '0;
            digest_out   <= '0;
`ifdef SHA256_SCHED_TIMEOUT_EN
            wait_cnt_q   <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            core_start   <= 1'b0;
            digest_valid <= '0;
            unique case (state_q)
                StIdle: begin
                    if (|req_valid) begin
                        lat_g_q      <= grant_idx;
                        lat_last_q   <= req_last[grant_idx];
                        core_block   <= req_block[grant_idx*BLOCK_W +: BLOCK_W];
                        core_hash_in <= req_first[grant_idx] ? SHA256_IV : ctx_q[grant_idx];
                        rr_ptr_q     <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0
                                                                           : grant_idx + 1'b1;
                        core_start   <= 1'b1;
                        state_q      <= StIssue;
                    end
                end
                StIssue: begin
`ifdef SHA256_SCHED_TIMEOUT_EN
                    wait_cnt_q <= '0;
`endif
                    state_q <= StWait;
                end
                StWait: begin
                    if (core_done) begin
                        ctx_q[lat_g_q] <= core_hash_out;
                        // Digest pulses during WRITEBACK, carrying the freshly captured context.
                        if (lat_last_q) begin
                            digest_out   <= core_hash_out;
                            digest_valid <= NUM_REQ'(1) << lat_g_q;
                        end
                        state_q <= StWriteback;
                    end
`ifdef SHA256_SCHED_TIMEOUT_EN
                    else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        timeout_q      <= 1'b1;
                        ctx_q[lat_g_q] <= SHA256_IV;
                        state_q        <= StIdle;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
`endif
                end
                StWriteback: begin
                    if (lat_last_q) ctx_q[lat_g_q] <= SHA256_IV;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_block_scheduler.sv
// Scoreboard bench: random per-requester block streams checked against a message-level
// SHA-256 chaining model, plus known-answer, arbitration, reset and timeout scenarios.
module tb_sha256_block_scheduler;

    localparam int NREQ = 2;
    localparam int TO   = 16;

    localparam logic [255:0] IV =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] ABC_DIG =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] TWO_DIG =
        256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [511:0] ABC_BLK = {32'h61626380, 416'h0, 64'h18};

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NREQ-1:0]     req_valid, req_first, req_last, req_ready, digest_valid;
    logic [NREQ*512-1:0] req_block;
    logic                core_start, core_done, busy, timeout_err;
    logic [511:0]        core_block;
    logic [255:0]        core_hash_in, core_hash_out, digest_out;

    always #5 clk = ~clk;

    sha256_block_scheduler #(
        .NUM_REQ        (NREQ),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_block     (req_block),
        .req_first     (req_first),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .core_start    (core_start),
        .core_block    (core_block),
        .core_hash_in  (core_hash_in),
        .core_done     (core_done),
        .core_hash_out (core_hash_out),
        .digest_valid  (digest_valid),
        .digest_out    (digest_out),
        .busy          (busy),
        .timeout_err   (timeout_err)
    );

    typedef struct {
        logic [511:0] blk;
        logic         first;
        logic         last;
    } item_t;

    int checks = 0;
    int errors = 0;
    item_t        pend [NREQ][$];
    logic [255:0] exp_q [NREQ][$];
    logic [255:0] mctx [NREQ];
    logic [255:0] last_dig [NREQ];
    int           grant_log [$];
    int           core_mode = 0;
    int           late_cnt = 0;
    int           late_seen = 0;

    logic [31:0] k_tab [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
        32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
        32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
        32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
        32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
        32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Full compression including feed-forward, as the core is specified to return.
    function automatic logic [255:0] sha_compress(input logic [255:0] h, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
        for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 64; t++)
            w[t] = w[t-16] + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-7]
                 + (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10));
        {a, b, c, d, e, f, g, hh} = h;
        for (int t = 0; t < 64; t++) begin
            t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + k_tab[t] + w[t];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
                h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
    endfunction

    function automatic logic [511:0] two_blk(input int n);
        string        s = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
        logic [511:0] b = '0;
        if (n == 0) begin
            for (int j = 0; j < 56; j++) b[511-8*j -: 8] = s[j];
            b[511-8*56 -: 8] = 8'h80;
        end else begin
            b[63:0] = 64'd448;
        end
        return b;
    endfunction

    function automatic logic [511:0] rand_blk();
        logic [511:0] b;
        for (int j = 0; j < 16; j++) b[j*32 +: 32] = $urandom();
        return b;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic enq(input int r, input logic [511:0] blk, input logic first, input logic last);
        item_t it;
        it.blk = blk; it.first = first; it.last = last;
        pend[r].push_back(it);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) mctx[i] = IV;
        grant_log.delete();
    endtask

    // Core model: answers each start after a random latency, or fires a stray done on request.
    initial begin
        core_done = 1'b0;
        core_hash_out = '0;
        forever begin
            @(negedge clk);
            if (late_cnt != late_seen) begin
                late_seen = late_cnt;
                core_hash_out = {8{$urandom()}};
                core_done = 1'b1;
                @(negedge clk);
                core_done = 1'b0;
            end else if (core_start && core_mode == 0) begin
                repeat ($urandom_range(1, 6)) @(negedge clk);
                core_hash_out = sha_compress(core_hash_in, core_block);
                core_done = 1'b1;
                @(negedge clk);
                core_done = 1'b0;
            end
        end
    end

    // Monitor: every digest pulse is popped against the scoreboard of its requester.
    always @(negedge clk) begin
        if (rst_n && |digest_valid) begin
            check("digest_onehot", 256'($onehot(digest_valid)), 256'd1);
            for (int i = 0; i < NREQ; i++) begin
                if (digest_valid[i]) begin
                    last_dig[i] = digest_out;
                    if (exp_q[i].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_digest req%0d: got %h expected none", i, digest_out);
                    end else begin
                        check($sformatf("digest_req%0d", i), digest_out, exp_q[i].pop_front());
                    end
                end
            end
        end
    end

    task automatic run_traffic(input int max_cycles, input bit steady);
        int  cyc = 0;
        bit  idle;
        item_t it;
        while (cyc < max_cycles) begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < NREQ; i++) begin
                if (pend[i].size() != 0 && (steady || $urandom_range(0, 3) != 0)) begin
                    req_valid[i] = 1'b1;
                    req_block[i*512 +: 512] = pend[i][0].blk;
                    req_first[i] = pend[i][0].first;
                    req_last[i] = pend[i][0].last;
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
            #2;
            if (|req_ready) check("ready_onehot", 256'($onehot(req_ready)), 256'd1);
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i]) begin
                    check($sformatf("ready_valid%0d", i), 256'(req_valid[i]), 256'd1);
                    it = pend[i].pop_front();
                    grant_log.push_back(i);
                    if (it.first) mctx[i] = IV;
                    mctx[i] = sha_compress(mctx[i], it.blk);
                    if (it.last) begin
                        exp_q[i].push_back(mctx[i]);
                        mctx[i] = IV;
                    end
                end
            end
            idle = !busy;
            for (int i = 0; i < NREQ; i++)
                if (pend[i].size() != 0 || exp_q[i].size() != 0) idle = 1'b0;
            if (idle) break;
        end
        req_valid = '0;
        if (cyc >= max_cycles) begin
            checks++;
            errors++;
            $display("FAIL traffic_timeout: got %0d cycles expected fewer than %0d", cyc, max_cycles);
        end
    endtask

    initial begin
        req_valid = '0;
        req_first = '0;
        req_last = '0;
        req_block = '0;
        for (int i = 0; i < NREQ; i++) begin
            mctx[i] = IV;
            last_dig[i] = '0;
        end
        repeat (3) @(negedge clk);
        check("rst_req_ready", 256'(req_ready), 256'd0);
        check("rst_core_start", 256'(core_start), 256'd0);
        check("rst_digest_valid", 256'(digest_valid), 256'd0);
        check("rst_digest_out", digest_out, 256'd0);
        check("rst_core_block", core_block[255:0] | core_block[511:256], 256'd0);
        check("rst_core_hash_in", core_hash_in, 256'd0);
        check("rst_busy", 256'(busy), 256'd0);
        check("rst_timeout_err", 256'(timeout_err), 256'd0);
        rst_n = 1'b1;

        // Single-block "abc" known answer.
        enq(0, ABC_BLK, 1'b1, 1'b1);
        run_traffic(500, 1'b0);
        check("abc_kat", last_dig[0], ABC_DIG);

        // Simultaneous requests right after reset alternate 0,1,0,1.
        do_reset();
        for (int j = 0; j < 2; j++) begin
            enq(0, rand_blk(), 1'b1, 1'b1);
            enq(1, rand_blk(), 1'b1, 1'b1);
        end
        run_traffic(500, 1'b1);
        check("grant_count", 256'(grant_log.size()), 256'd4);
        for (int j = 0; j < 4 && j < grant_log.size(); j++)
            check($sformatf("grant_order%0d", j), 256'(grant_log[j]), 256'(j % 2));

        // Two-block message on requester 0 interleaved with "abc" on requester 1.
        enq(0, two_blk(0), 1'b1, 1'b0);
        enq(0, two_blk(1), 1'b0, 1'b1);
        enq(1, ABC_BLK, 1'b1, 1'b1);
        run_traffic(500, 1'b1);
        check("two_block_kat", last_dig[0], TWO_DIG);
        check("interleave_abc", last_dig[1], ABC_DIG);

        // Random first/last patterns with sporadic valid drops.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < NREQ; i++)
                for (int b = 0; b < 8; b++)
                    enq(i, rand_blk(), $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
            run_traffic(3000, 1'b0);
        end

        // Reset in WAIT, stray late done, then continuation blocks must chain from IV.
        core_mode = 1;
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_block[511:0] = ABC_BLK;
        req_first[0] = 1'b1;
        req_last[0] = 1'b1;
        #2;
        check("wait_grant", 256'(req_ready[0]), 256'd1);
        @(negedge clk);
        req_valid = '0;
        repeat (4) @(negedge clk);
        check("wait_busy", 256'(busy), 256'd1);
        do_reset();
        check("post_rst_busy", 256'(busy), 256'd0);
        late_cnt++;
        core_mode = 0;
        repeat (5) @(negedge clk);
        check("late_done_busy", 256'(busy), 256'd0);
        enq(0, ABC_BLK, 1'b0, 1'b1);
        enq(1, ABC_BLK, 1'b0, 1'b1);
        run_traffic(500, 1'b0);
        check("post_rst_abc0", last_dig[0], ABC_DIG);
        check("post_rst_abc1", last_dig[1], ABC_DIG);

`ifdef SHA256_SCHED_TIMEOUT_EN
        begin
            int k = 0;
            core_mode = 1;
            @(negedge clk);
            req_valid[0] = 1'b1;
            req_block[511:0] = ABC_BLK;
            req_first[0] = 1'b1;
            req_last[0] = 1'b1;
            @(negedge clk);
            req_valid = '0;
            while (!timeout_err && k < TO + 10) begin
                @(negedge clk);
                k++;
            end
            check("timeout_latency", 256'(k), 256'(TO + 1));
            check("timeout_busy", 256'(busy), 256'd0);
            core_mode = 0;
            enq(0, ABC_BLK, 1'b0, 1'b1);
            run_traffic(500, 1'b0);
            check("timeout_abc", last_dig[0], ABC_DIG);
            check("timeout_sticky", 256'(timeout_err), 256'd1);
        end
`else
        check("timeout_err_tied", 256'(timeout_err), 256'd0);
`endif

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
